// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry skid-buffered pipeline stage register with flush,
//               zeroed bubbles and saturating bubble/flush counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
    parameter int CTRL_W = 12,
    parameter int DATA_W = 32,
    parameter int NLANE  = 5,
    parameter int TAG_W  = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [CTRL_W-1:0]       in_ctrl,
    input  logic [NLANE*DATA_W-1:0] in_data,
    input  logic [TAG_W-1:0]        in_tag,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [CTRL_W-1:0]       out_ctrl,
    output logic [NLANE*DATA_W-1:0] out_data,
    output logic [TAG_W-1:0]        out_tag,
    output logic [1:0]              occ,
    output logic [CNT_W-1:0]        bubble_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    localparam int DW = NLANE * DATA_W;

    localparam logic [1:0] c_EMPTY = 2'd0;
    localparam logic [1:0] c_ONE   = 2'd1;
    localparam logic [1:0] c_TWO   = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [1:0]        state_q, state_d;
    logic [CTRL_W-1:0] head_ctrl_q, head_ctrl_d, tail_ctrl_q, tail_ctrl_d;
    logic [DW-1:0]     head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [TAG_W-1:0]  head_tag_q,  head_tag_d,  tail_tag_q,  tail_tag_d;
    logic [CNT_W-1:0]  bubble_q, bubble_d, flush_q, flush_d;

    logic w_accept;
    logic w_drain;

    assign w_accept = in_valid && in_ready && !flush;
    assign w_drain  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = c_EMPTY;
        end else begin
            case (state_q)
                c_EMPTY: if (w_accept) state_d = c_ONE;
                c_ONE: begin
                    if (w_accept && !w_drain)      state_d = c_TWO;
                    else if (!w_accept && w_drain) state_d = c_EMPTY;
                end
                c_TWO:   if (w_drain) state_d = c_ONE;
                default: state_d = c_EMPTY;
            endcase
        end
    end

    // Outputs: handshake derives from registered state only
    always_comb begin
        in_ready  = (state_q != c_TWO);
        out_valid = (state_q != c_EMPTY);
        occ       = state_q;
    end

    // Entry steering between input, head and tail
    always_comb begin
        head_ctrl_d = head_ctrl_q;
        head_data_d = head_data_q;
        head_tag_d  = head_tag_q;
        tail_ctrl_d = tail_ctrl_q;
        tail_data_d = tail_data_q;
        tail_tag_d  = tail_tag_q;
        if (!flush) begin
            if (state_q == c_TWO && w_drain) begin
                head_ctrl_d = tail_ctrl_q;
                head_data_d = tail_data_q;
                head_tag_d  = tail_tag_q;
            end else if (w_accept && (state_q == c_EMPTY || w_drain)) begin
                head_ctrl_d = in_ctrl;
                head_data_d = in_data;
                head_tag_d  = in_tag;
            end else if (w_accept && state_q == c_ONE) begin
                tail_ctrl_d = in_ctrl;
                tail_data_d = in_data;
                tail_tag_d  = in_tag;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ctrl_q <= '0;
            head_data_q <= '0;
            head_tag_q  <= '0;
            tail_ctrl_q <= '0;
            tail_data_q <= '0;
            tail_tag_q  <= '0;
        end else begin
            head_ctrl_q <= head_ctrl_d;
            head_data_q <= head_data_d;
            head_tag_q  <= head_tag_d;
            tail_ctrl_q <= tail_ctrl_d;
            tail_data_q <= tail_data_d;
            tail_tag_q  <= tail_tag_d;
        end
    end

    // Saturating performance counters
    always_comb begin
        bubble_d = bubble_q;
        flush_d  = flush_q;
        if (out_ready && !out_valid && bubble_q != c_CNT_MAX) begin
            bubble_d = bubble_q + c_CNT_ONE;
        end
        if (flush && (state_q != c_EMPTY || in_valid) && flush_q != c_CNT_MAX) begin
            flush_d = flush_q + c_CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_q <= '0;
            flush_q  <= '0;
        end else begin
            bubble_q <= bubble_d;
            flush_q  <= flush_d;
        end
    end

    // Bubbles present all-zero fields so nothing downstream gets written
    assign out_ctrl   = out_valid ? head_ctrl_q : '0;
    assign out_data   = out_valid ? head_data_q : '0;
    assign out_tag    = out_valid ? head_tag_q  : '0;
    assign bubble_cnt = bubble_q;
    assign flush_cnt  = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Directed table-driven bench for pipe_stage_reg (counters narrowed to 4 bits).
module tb_pipe_stage_reg;

    localparam int CTRL_W = 12;
    localparam int DATA_W = 32;
    localparam int NLANE  = 5;
    localparam int TAG_W  = 8;
    localparam int CNT_W  = 4;
    localparam int DW     = NLANE * DATA_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DW-1:0]     in_data;
    logic [TAG_W-1:0]  in_tag;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DW-1:0]     out_data;
    logic [TAG_W-1:0]  out_tag;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    pipe_stage_reg #(
        .CTRL_W(CTRL_W), .DATA_W(DATA_W), .NLANE(NLANE), .TAG_W(TAG_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_tag(in_tag),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_tag(out_tag),
        .occ(occ), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] tag;
        logic       ordy;
        logic       fl;
        logic       ev;
        logic [7:0] etag;
        logic [1:0] eocc;
        logic       eir;
        logic [3:0] ebub;
        logic [3:0] eflc;
    } vec_t;

    vec_t vq[$];
    int   n_chk = 0;
    int   n_bad = 0;

    function automatic logic [DW-1:0] mk_data(input logic [7:0] t);
        logic [DW-1:0] d;
        d = '0;
        for (int k = 0; k < NLANE; k++)
            d[k*DATA_W +: DATA_W] = {t, ~t, t ^ 8'(k), 8'(k + 1)};
        return d;
    endfunction

    function automatic logic [CTRL_W-1:0] mk_ctrl(input logic [7:0] t);
        return {4'h9, t};
    endfunction

    task automatic add(input logic v, input logic [7:0] t, input logic ordy, input logic fl,
                       input logic ev, input logic [7:0] etag, input logic [1:0] eocc,
                       input logic eir, input logic [3:0] ebub, input logic [3:0] eflc);
        vec_t r;
        r.v = v; r.tag = t; r.ordy = ordy; r.fl = fl;
        r.ev = ev; r.etag = etag; r.eocc = eocc; r.eir = eir; r.ebub = ebub; r.eflc = eflc;
        vq.push_back(r);
    endtask

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] t, input logic ordy, input logic fl);
        in_valid  = v;
        in_tag    = t;
        in_ctrl   = mk_ctrl(t);
        in_data   = mk_data(t);
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic check_all(input string nm, input logic ev, input logic [7:0] etag,
                             input logic [1:0] eocc, input logic eir,
                             input logic [3:0] ebub, input logic [3:0] eflc);
        chk({nm, ".out_valid"}, DW'(out_valid), DW'(ev));
        chk({nm, ".out_tag"},   DW'(out_tag),   ev ? DW'(etag) : '0);
        chk({nm, ".out_ctrl"},  DW'(out_ctrl),  ev ? DW'(mk_ctrl(etag)) : '0);
        chk({nm, ".out_data"},  out_data,       ev ? mk_data(etag) : '0);
        chk({nm, ".occ"},       DW'(occ),       DW'(eocc));
        chk({nm, ".in_ready"},  DW'(in_ready),  DW'(eir));
        chk({nm, ".bubble"},    DW'(bubble_cnt), DW'(ebub));
        chk({nm, ".flushc"},    DW'(flush_cnt),  DW'(eflc));
    endtask

    task automatic step(input string nm, input vec_t r);
        @(negedge clk);
        drive(r.v, r.tag, r.ordy, r.fl);
        @(posedge clk);
        #1;
        check_all(nm, r.ev, r.etag, r.eocc, r.eir, r.ebub, r.eflc);
    endtask

    initial begin
        //   v  tag    ordy fl  ev etag   occ ir  bub flc
        // single entry, one-cycle latency, then bubble
        add(1, 8'h11, 1, 0,  1, 8'h11, 1, 1, 1, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 1, 0);
        // streaming 1..8
        add(1, 8'h01, 1, 0,  1, 8'h01, 1, 1, 2, 0);
        for (int t = 2; t <= 8; t++)
            add(1, 8'(t), 1, 0, 1, 8'(t), 1, 1, 2, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 2, 0);
        // backpressure fills to TWO, then drains in order
        add(1, 8'h0A, 0, 0,  1, 8'h0A, 1, 1, 2, 0);
        add(1, 8'h0B, 0, 0,  1, 8'h0A, 2, 0, 2, 0);
        add(1, 8'h0C, 0, 0,  1, 8'h0A, 2, 0, 2, 0);
        add(1, 8'h0C, 1, 0,  1, 8'h0B, 1, 1, 2, 0);
        add(1, 8'h0C, 1, 0,  1, 8'h0C, 1, 1, 2, 0);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 2, 0);
        // flush in TWO with incoming 0x05
        add(1, 8'h21, 0, 0,  1, 8'h21, 1, 1, 2, 0);
        add(1, 8'h22, 0, 0,  1, 8'h21, 2, 0, 2, 0);
        add(1, 8'h05, 0, 1,  0, 8'h00, 0, 1, 2, 1);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 3, 1);
        // flush coinciding with drain; flush on empty with and without input
        add(1, 8'h31, 0, 0,  1, 8'h31, 1, 1, 3, 1);
        add(1, 8'h32, 1, 1,  0, 8'h00, 0, 1, 3, 2);
        add(0, 8'h00, 0, 1,  0, 8'h00, 0, 1, 3, 2);
        add(1, 8'h33, 1, 1,  0, 8'h00, 0, 1, 4, 3);
        // hold in ONE
        add(1, 8'h41, 0, 0,  1, 8'h41, 1, 1, 4, 3);
        add(0, 8'h00, 0, 0,  1, 8'h41, 1, 1, 4, 3);
        add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 4, 3);

        rst = 1'b1;
        drive(0, 8'h00, 0, 0);
        #2;
        check_all("reset", 0, 8'h00, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++)
            step($sformatf("v%0d", i), vq[i]);

        // bubble counter: 4 -> 15 after 11 idle cycles, then saturates
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive(0, 8'h00, 1, 0);
        end
        @(posedge clk);
        #1;
        chk("bub_reach_max", DW'(bubble_cnt), DW'(4'hF));
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive(0, 8'h00, 1, 0);
        end
        @(posedge clk);
        #1;
        chk("bub_saturate", DW'(bubble_cnt), DW'(4'hF));

        // asynchronous reset with two entries held
        begin
            vec_t r;
            r.v = 1; r.tag = 8'h51; r.ordy = 0; r.fl = 0;
            r.ev = 1; r.etag = 8'h51; r.eocc = 1; r.eir = 1; r.ebub = 4'hF; r.eflc = 3;
            step("pre_rst0", r);
            r.tag = 8'h52; r.eocc = 2; r.eir = 0;
            step("pre_rst1", r);
        end
        @(negedge clk);
        drive(0, 8'h00, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 0, 8'h00, 0, 1, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        begin
            vec_t r;
            r.v = 1; r.tag = 8'h77; r.ordy = 1; r.fl = 0;
            r.ev = 1; r.etag = 8'h77; r.eocc = 1; r.eir = 1; r.ebub = 1; r.eflc = 0;
            step("post_rst0", r);
            r.v = 0; r.tag = 8'h00; r.ev = 0; r.etag = 8'h00; r.eocc = 0;
            step("post_rst1", r);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 12: width of the control bundle (wreg, m2reg, wmem, aluc, shift, aluimm, branch, regrt, ...).
REQ-002 The block SHALL have parameter DATA_W, default 32: width of one data lane.
REQ-003 The block SHALL have parameter NLANE, default 5: number of data lanes (data_a, data_b, imm, pc4, rt/rd packed).
REQ-004 The block SHALL have parameter TAG_W, default 8: width of the instruction tag (type + number).
REQ-005 The block SHALL have parameter CNT_W, default 16: width of the performance counters.
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 in_valid  in  1  upstream entry valid.
REQ-009 in_ready  out  1  stage can accept an entry this cycle.
REQ-010 in_ctrl  in  CTRL_W  control bundle.
REQ-011 in_data  in  NLANE*DATA_W  data lanes; lane k occupies bits [k*DATA_W +: DATA_W].
REQ-012 in_tag  in  TAG_W  instruction tag.
REQ-013 flush  in  1  synchronous kill of all held and incoming entries.
REQ-014 out_valid  out  1  head entry valid.
REQ-015 out_ready  in  1  downstream accepts head entry.
REQ-016 out_ctrl, out_data, out_tag  out  CTRL_W, NLANE*DATA_W, TAG_W  head entry fields.
REQ-017 occ  out  2  entries held (0..2).
REQ-018 bubble_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-019 Storage SHALL be a 2-entry skid buffer (head, tail) with state EMPTY (occ 0), ONE (occ 1) or TWO (occ 2).
REQ-020 in_ready SHALL equal (state != TWO) and SHALL depend only on registered state, never on out_ready.
REQ-021 Accept SHALL occur when in_valid && in_ready && !flush; drain SHALL occur when out_valid && out_ready.
REQ-022 Latency SHALL be one cycle: an entry accepted in EMPTY appears on out_* with out_valid=1 in the next cycle.
REQ-023 Transitions: EMPTY + accept -> ONE.
REQ-024 ONE + accept, no drain -> TWO, with the new entry in tail.
REQ-025 ONE + accept + drain -> ONE, with the new entry in head.
REQ-026 ONE + drain, no accept -> EMPTY.
REQ-027 TWO + drain -> ONE, with tail moved to head; no accept is possible in TWO.
REQ-028 Any state without accept or drain SHALL hold its entries unchanged.
REQ-029 Order SHALL be strictly FIFO; no entry is duplicated or lost except by flush.
REQ-030 flush SHALL take priority over all other events: next state EMPTY, the incoming entry dropped, any drain that cycle still counted as delivered.
REQ-031 When out_valid=0, out_ctrl, out_data and out_tag SHALL be all zeros, so a bubble never writes registers or memory.
REQ-032 out_* SHALL be driven directly from head registers, with no combinational path from in_* to out_*.
REQ-033 bubble_cnt SHALL increment by 1 each cycle with out_ready=1 and out_valid=0, and SHALL saturate at all-ones.
REQ-034 flush_cnt SHALL increment by 1 each cycle where flush=1 and (occ>0 or in_valid=1), and SHALL saturate at all-ones.
REQ-035 Field widths SHALL pass through unmodified; there is no arithmetic on data.

Reset
REQ-036 While rst=1, state SHALL be EMPTY, occ=0, out_valid=0, in_ready=1, all out_* fields zero, and bubble_cnt=flush_cnt=0, asynchronously.
REQ-037 Reset asserted mid-operation SHALL discard held entries immediately; the first accept after deassertion SHALL behave as from EMPTY.

Verification
REQ-038 Reset then in_valid=1, in_tag=0x11, out_ready=1 for one cycle -> next cycle out_valid=1, out_tag=0x11, occ=1; following cycle out_valid=0 and out_ctrl=0.
REQ-039 Streaming tags 1..8 back-to-back with out_ready held 1 -> out_tag 1..8 on consecutive cycles, in_ready always 1, occ never 2.
REQ-040 out_ready=0 while sending tags 0xA,0xB,0xC -> occ=2, in_ready=0, 0xC held upstream; out_ready=1 -> 0xA, 0xB, 0xC in order, no loss.
REQ-041 occ=2 with flush=1 and in_valid=1 (tag 0x5) -> next cycle occ=0, out_valid=0, flush_cnt +1, 0x5 never appears.
REQ-042 bubble_cnt preloaded via 2^CNT_W-1 idle cycles with out_ready=1 -> bubble_cnt stays all-ones; rst pulse mid-stream with occ=2 -> occ=0 and counters 0 immediately.
